// File: rtl/eb3_pkg.sv
// eb3_pkg: command codes, HDLC constants and transmitter state encoding
package eb3_pkg;
    localparam logic [7:0] CMD_DATA  = 8'h00;
    localparam logic [7:0] CMD_EOF   = 8'h01;
    localparam logic [7:0] CMD_ABORT = 8'h02;
    localparam logic [7:0] CMD_NOP   = 8'hFF;
    localparam logic [7:0] HDLC_FLAG = 8'h7E;
    localparam logic [15:0] CRC_POLY = 16'h8408;
    localparam logic [15:0] CRC_INIT = 16'hFFFF;
    typedef enum logic [2:0] {S_IDLE, S_OPEN, S_DATA, S_CRC, S_CLOSE, S_ABORT} state_t;
endpackage

// File: rtl/hdlc_tx_if.sv
// hdlc_tx_if: word request/strobe handshake between the SPI master and the HDLC transmitter
interface hdlc_tx_if;
    logic        tx_request;
    logic [15:0] tx_data;
    logic        tx_strobe;
    modport master(input tx_request, output tx_data, tx_strobe);
    modport slave(output tx_request, input tx_data, tx_strobe);
endinterface

// File: rtl/crc16_serial.sv
// crc16_serial: bit-serial reflected CRC-16/X-25 register
module crc16_serial
    import eb3_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        init,
    input  logic        en,
    input  logic        din,
    output logic [15:0] crc
);
    always_ff @(posedge clk or posedge reset)
        if (reset)
            crc <= CRC_INIT;
        else if (init)
            crc <= CRC_INIT;
        else if (en)
            crc <= (crc >> 1) ^ ((crc[0] ^ din) ? CRC_POLY : 16'h0000);
endmodule

// File: rtl/hdlc_tx.sv
// hdlc_tx: HDLC framer fed word-by-word from SPI; flags, zero-bit stuffing and CRC-16 on a synchronised line clock
module hdlc_tx
    import eb3_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       line_clk,
    hdlc_tx_if.slave   spi,
    output logic       txd,
    output logic       tx_en,
    output logic       underrun
);
    logic [2:0]  lsync;
    logic        tick;
    logic        hold_full, armed;
    logic [15:0] hold;
    logic        cmd_ok, take, take_ok, eff_full, boundary, consume, full_n, armed_n;
    logic [15:0] eff;
    logic [7:0]  eff_cmd;
    state_t      state;
    logic [3:0]  bcnt;
    logic [2:0]  ones;
    logic [7:0]  shreg;
    logic [15:0] crc;
    logic        stuff;

    always_ff @(posedge clk or posedge reset)
        if (reset)
            lsync <= 3'b000;
        else
            lsync <= {lsync[1:0], line_clk};
    assign tick = lsync[2] & ~lsync[1];

    // A word strobed on the same cycle as a decision is used directly, as if already held
    assign cmd_ok   = spi.tx_data[15:8] inside {CMD_DATA, CMD_EOF, CMD_ABORT};
    assign take     = spi.tx_strobe & spi.tx_request;
    assign take_ok  = take & cmd_ok;
    assign eff_full = hold_full | take_ok;
    assign eff      = hold_full ? hold : spi.tx_data;
    assign eff_cmd  = eff[15:8];
    assign stuff    = ones == 3'd5;
    assign boundary = tick && state == S_DATA && !stuff && bcnt == 4'd7;
    assign consume  = eff_full && ((tick && state == S_IDLE) || boundary);
    assign full_n   = eff_full & ~consume;
    assign armed_n  = ~spi.tx_strobe | (armed & ~take);

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            hold_full      <= 1'b0;
            hold           <= 16'h0000;
            armed          <= 1'b0;
            spi.tx_request <= 1'b0;
        end else begin
            hold_full      <= full_n;
            armed          <= armed_n;
            spi.tx_request <= ~full_n & armed_n;
            if (take_ok)
                hold <= spi.tx_data;
        end

    crc16_serial u_crc (
        .clk  (clk),
        .reset(reset),
        .init (tick && state == S_OPEN),
        .en   (tick && state == S_DATA && !stuff),
        .din  (shreg[0]),
        .crc  (crc)
    );

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state    <= S_IDLE;
            bcnt     <= 4'd0;
            ones     <= 3'd0;
            shreg    <= 8'h00;
            txd      <= 1'b1;
            tx_en    <= 1'b0;
            underrun <= 1'b0;
        end else begin
            underrun <= 1'b0;
            if (tick) begin
                case (state)
                    S_IDLE: begin
                        tx_en <= 1'b0;
                        txd   <= 1'b1;
                        bcnt  <= 4'd0;
                        if (eff_full && eff_cmd == CMD_DATA) begin
                            state <= S_OPEN;
                            shreg <= eff[7:0];
                        end
                    end
                    S_OPEN: begin
                        tx_en <= 1'b1;
                        txd   <= HDLC_FLAG[bcnt[2:0]];
                        ones  <= 3'd0;
                        bcnt  <= bcnt == 4'd7 ? 4'd0 : bcnt + 4'd1;
                        if (bcnt == 4'd7)
                            state <= S_DATA;
                    end
                    S_DATA:
                        if (stuff) begin
                            txd  <= 1'b0;
                            ones <= 3'd0;
                        end else begin
                            txd   <= shreg[0];
                            ones  <= shreg[0] ? ones + 3'd1 : 3'd0;
                            shreg <= shreg >> 1;
                            bcnt  <= bcnt == 4'd7 ? 4'd0 : bcnt + 4'd1;
                            if (bcnt == 4'd7) begin
                                if (!eff_full) begin
                                    state    <= S_ABORT;
                                    underrun <= 1'b1;
                                end else if (eff_cmd == CMD_DATA)
                                    shreg <= eff[7:0];
                                else
                                    state <= eff_cmd == CMD_EOF ? S_CRC : S_ABORT;
                            end
                        end
                    S_CRC:
                        if (stuff) begin
                            txd  <= 1'b0;
                            ones <= 3'd0;
                        end else begin
                            txd   <= ~crc[bcnt];
                            ones  <= ~crc[bcnt] ? ones + 3'd1 : 3'd0;
                            bcnt  <= bcnt + 4'd1;
                            if (bcnt == 4'd15)
                                state <= S_CLOSE;
                        end
                    S_CLOSE:
                        if (stuff) begin
                            txd  <= 1'b0;
                            ones <= 3'd0;
                        end else begin
                            txd  <= HDLC_FLAG[bcnt[2:0]];
                            bcnt <= bcnt + 4'd1;
                            if (bcnt == 4'd7)
                                state <= S_IDLE;
                        end
                    S_ABORT: begin
                        txd  <= 1'b1;
                        bcnt <= bcnt + 4'd1;
                        if (bcnt == 4'd7)
                            state <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
endmodule

// File: tb/tb_hdlc_tx.sv
// tb_hdlc_tx: randomized SPI-side stimulus with a queue scoreboard of expected line bits
module tb_hdlc_tx;
    logic clk = 1'b0, reset = 1'b1, line_clk = 1'b1;
    logic txd, tx_en, underrun;
    int n_chk = 0, n_pass = 0, got = 0, ur_cnt = 0, ur_exp = 0, takes = 0;
    logic       exp_q[$];
    logic [7:0] frame_b[$];

    hdlc_tx_if spi();

    hdlc_tx dut (
        .clk     (clk),
        .reset   (reset),
        .line_clk(line_clk),
        .spi     (spi),
        .txd     (txd),
        .tx_en   (tx_en),
        .underrun(underrun)
    );

    always #20 clk = ~clk;
    initial begin
        #777;
        forever #1000 line_clk = ~line_clk;
    end

    always @(posedge clk) begin
        if (underrun) ur_cnt <= ur_cnt + 1;
        if (spi.tx_strobe && spi.tx_request) takes <= takes + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Expected line bits for one frame; term 0=EOF, 1=ABORT, 2=underrun
    function automatic void push_expected(input int term);
        logic [15:0] c = 16'hFFFF;
        logic [15:0] fcs;
        logic [7:0]  flag = 8'h7E;
        logic        pl[$];
        int          ones = 0;
        for (int i = 0; i < 8; i++) exp_q.push_back(flag[i]);
        foreach (frame_b[k]) begin
            c = c ^ {8'h00, frame_b[k]};
            for (int j = 0; j < 8; j++) c = c[0] ? (c >> 1) ^ 16'h8408 : c >> 1;
            for (int i = 0; i < 8; i++) pl.push_back(frame_b[k][i]);
        end
        fcs = ~c;
        if (term == 0)
            for (int i = 0; i < 16; i++) pl.push_back(fcs[i]);
        foreach (pl[k]) begin
            if (ones == 5) begin
                exp_q.push_back(1'b0);
                ones = 0;
            end
            exp_q.push_back(pl[k]);
            ones = pl[k] ? ones + 1 : 0;
        end
        if (term == 0) begin
            if (ones == 5) exp_q.push_back(1'b0);
            for (int i = 0; i < 8; i++) exp_q.push_back(flag[i]);
        end else begin
            for (int i = 0; i < 8; i++) exp_q.push_back(1'b1);
            if (term == 2) ur_exp++;
        end
    endfunction

    initial begin
        logic e;
        forever begin
            @(negedge line_clk);
            repeat (6) @(posedge clk);
            #1;
            if (!reset && tx_en) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL extra_bit: got txd=%0b while tx_en=1, expected no bit", txd);
                end else begin
                    e = exp_q.pop_front();
                    check("line_bit", 32'(txd), 32'(e));
                    got++;
                end
            end
        end
    end

    task automatic send_word(input logic [15:0] w, input int hold, input int dly);
        int t = 0;
        @(posedge clk);
        #1;
        while (!spi.tx_request && t < 3000) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (!spi.tx_request) begin
            check("req_timeout", 32'(spi.tx_request), 32'd1);
            return;
        end
        repeat (dly) @(posedge clk);
        #1;
        spi.tx_data   = w;
        spi.tx_strobe = 1'b1;
        @(posedge clk);
        #1;
        check("req_drop", 32'(spi.tx_request), 32'd0);
        repeat (hold) begin
            @(posedge clk);
            #1;
            check("req_low_hold", 32'(spi.tx_request), 32'd0);
        end
        spi.tx_strobe = 1'b0;
    endtask

    task automatic send_frame(input int term, input int hold_first, input bit rnd);
        push_expected(term);
        foreach (frame_b[k]) begin
            if (rnd && $urandom_range(0, 1) == 1)
                send_word({8'($urandom_range(3, 255)), 8'($urandom)}, 0, $urandom_range(0, 20));
            send_word({8'h00, frame_b[k]}, k == 0 ? hold_first : 0, rnd ? $urandom_range(0, 60) : 36);
        end
        if (term == 0) send_word({8'h01, 8'($urandom)}, 0, 36);
        else if (term == 1) send_word({8'h02, 8'($urandom)}, 0, 36);
        else while (exp_q.size() > 0) send_word(16'hFFFF, 0, 36);
    endtask

    task automatic wait_done();
        int t = 0;
        while (exp_q.size() > 0 && t < 10000) begin
            @(posedge clk);
            t++;
        end
        check("frame_done", 32'(exp_q.size()), 32'd0);
        repeat (3) @(negedge line_clk);
        repeat (6) @(posedge clk);
        #1;
        check("idle_en", 32'(tx_en), 32'd0);
        check("idle_txd", 32'(txd), 32'd1);
        check("underrun_cnt", 32'(ur_cnt), 32'(ur_exp));
    endtask

    initial begin
        int t, base, t0;
        spi.tx_strobe = 1'b0;
        spi.tx_data   = 16'h0000;
        repeat (5) @(posedge clk);
        #1;
        check("rst_req", 32'(spi.tx_request), 32'd0);
        check("rst_txd", 32'(txd), 32'd1);
        check("rst_en", 32'(tx_en), 32'd0);
        check("rst_underrun", 32'(underrun), 32'd0);
        reset = 1'b0;

        frame_b = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        send_frame(0, 0, 0);
        wait_done();

        frame_b = '{8'hFF};
        send_frame(0, 0, 0);
        wait_done();

        frame_b = '{8'h5A};
        send_frame(2, 0, 0);
        wait_done();

        frame_b = '{8'hC3};
        t0 = takes;
        send_frame(0, 20, 0);
        wait_done();
        check("take_count", 32'(takes - t0), 32'd2);

        frame_b = '{8'h55};
        send_frame(1, 0, 0);
        wait_done();

        for (int f = 0; f < 4; f++) begin
            frame_b.delete();
            for (int i = 0; i < $urandom_range(1, 4); i++)
                frame_b.push_back($urandom_range(0, 2) == 0 ? 8'hFF : 8'($urandom));
            send_frame($urandom_range(0, 1), 0, 1);
            wait_done();
        end

        frame_b = '{8'h00};
        base = got;
        send_frame(0, 0, 0);
        t = 0;
        while (got < base + 20 && t < 5000) begin
            @(posedge clk);
            t++;
        end
        check("reach_crc", 32'(got >= base + 20), 32'd1);
        @(posedge clk);
        #7;
        reset = 1'b1;
        exp_q.delete();
        #3;
        check("arst_en", 32'(tx_en), 32'd0);
        check("arst_txd", 32'(txd), 32'd1);
        check("arst_req", 32'(spi.tx_request), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        frame_b = '{8'hA5, 8'h7E};
        send_frame(0, 0, 0);
        wait_done();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
